// File: rtl/result_streamer_if.sv
// result_streamer_if: valid/ready beat stream carrying LANES elements plus row/matrix end markers.
interface result_streamer_if #(
    parameter int DATA_WIDTH = 16,
    parameter int LANES      = 4
) ();
    logic                        out_valid;
    logic                        out_ready;
    logic [DATA_WIDTH*LANES-1:0] out_data;
    logic                        out_row_last;
    logic                        out_last;

    modport master (output out_valid, out_data, out_row_last, out_last, input out_ready);
    modport slave  (input out_valid, out_data, out_row_last, out_last, output out_ready);
endinterface

// File: rtl/result_streamer.sv
// result_streamer: drains a held matrix row-major onto a valid/ready stream, LANES elements per beat.
// Define RESULT_RELU_EN to zero negative elements as each beat is loaded.
module result_streamer #(
    parameter int MATRIX_SIZE = 128,
    parameter int DATA_WIDTH  = 16,
    parameter int LANES       = 4
) (
    input  logic                                         clk,
    input  logic                                         rst_n,
    input  logic                                         done_in,
    input  logic [DATA_WIDTH*MATRIX_SIZE*MATRIX_SIZE-1:0] result_flat,
    input  logic                                         flush,
    output logic                                         busy,
    output logic                                         overrun,
    result_streamer_if.master                            s
);
    localparam int CW = $clog2(MATRIX_SIZE);
    localparam logic [CW-1:0] COL_LAST = CW'(MATRIX_SIZE - LANES);
    localparam logic [CW-1:0] ROW_LAST = CW'(MATRIX_SIZE - 1);

    typedef enum logic {IDLE, STREAM} state_t;

    state_t                      state_q, state_d;
    logic [CW-1:0]               row_q, row_d, col_q, col_d, nxt_row, nxt_col;
    logic                        valid_q, valid_d, row_last_q, row_last_d, last_q, last_d;
    logic                        overrun_q, overrun_d;
    logic [DATA_WIDTH*LANES-1:0] data_q, data_d, lanes;
    logic [DATA_WIDTH-1:0]       elem;
    logic                        hs, load, go_idle;

    always_comb begin
        hs        = valid_q && s.out_ready;
        load      = !flush && (state_q == IDLE ? done_in : hs && !last_q);
        go_idle   = flush || (state_q == STREAM && hs && last_q);
        nxt_col   = (state_q == IDLE || col_q == COL_LAST) ? '0 : col_q + CW'(LANES);
        nxt_row   = state_q == IDLE ? '0 : col_q == COL_LAST ? row_q + CW'(1) : row_q;
        elem      = '0;
        lanes     = '0;
        // the next beat is read straight out of the held matrix, never copied
        for (int k = 0; k < LANES; k++) begin
            elem = result_flat[(int'(nxt_row) * MATRIX_SIZE + int'(nxt_col) + k) * DATA_WIDTH +: DATA_WIDTH];
`ifdef RESULT_RELU_EN
            elem = elem[DATA_WIDTH-1] ? '0 : elem;
`endif
            lanes[k*DATA_WIDTH +: DATA_WIDTH] = elem;
        end
        state_d    = go_idle ? IDLE : load ? STREAM : state_q;
        row_d      = go_idle ? '0 : load ? nxt_row : row_q;
        col_d      = go_idle ? '0 : load ? nxt_col : col_q;
        valid_d    = state_d == STREAM;
        data_d     = go_idle ? '0 : load ? lanes : data_q;
        row_last_d = go_idle ? 1'b0 : load ? nxt_col == COL_LAST : row_last_q;
        last_d     = go_idle ? 1'b0 : load ? (nxt_col == COL_LAST && nxt_row == ROW_LAST) : last_q;
        overrun_d  = overrun_q || (done_in && state_q == STREAM);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            row_q      <= '0;
            col_q      <= '0;
            valid_q    <= 1'b0;
            data_q     <= '0;
            row_last_q <= 1'b0;
            last_q     <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            col_q      <= col_d;
            valid_q    <= valid_d;
            data_q     <= data_d;
            row_last_q <= row_last_d;
            last_q     <= last_d;
            overrun_q  <= overrun_d;
        end
    end

    assign busy           = valid_q;
    assign overrun        = overrun_q;
    assign s.out_valid    = valid_q;
    assign s.out_data     = data_q;
    assign s.out_row_last = row_last_q;
    assign s.out_last     = last_q;
endmodule
